// File: rtl/bsg_nonsynth_dramsim3_scoreboard_pkg.sv
// Shared types for the dramsim3 request tracker / data scoreboard.
// Field widths of the mismatch record are fixed here so benches can decode it.
package bsg_nonsynth_dramsim3_scoreboard_pkg;

  localparam int mm_ch_width_gp   = 8;
  localparam int mm_addr_width_gp = 64;
  localparam int mm_data_width_gp = 64;

  typedef enum logic [2:0] {
    CLEAR,
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } state_e;

  typedef struct packed {
    logic [mm_ch_width_gp-1:0]   ch;
    logic [mm_addr_width_gp-1:0] addr;
    logic [mm_data_width_gp-1:0] expected;
    logic [mm_data_width_gp-1:0] actual;
  } mismatch_s;

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/bsg_nonsynth_dramsim3_scoreboard_channel.sv
// One channel: data shadow, outstanding counter and read-return compare.
// Sweep clearing has priority over a shadow write in the same cycle.
module bsg_nonsynth_dramsim3_scoreboard_channel
  import bsg_nonsynth_dramsim3_scoreboard_pkg::*;
#(
  parameter int channel_addr_width_p = 29,
  parameter int data_width_p         = 512,
  parameter int check_width_p        = 32,
  parameter int col_lsb_p            = 5,
  parameter int shadow_addr_width_p  = 16,
  parameter int max_outstanding_p    = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     clear_v_i,
  input  logic [shadow_addr_width_p-1:0]           clear_idx_i,
  input  logic                                     v_i,
  input  logic                                     write_not_read_i,
  input  logic [channel_addr_width_p-1:0]          ch_addr_i,
  input  logic [data_width_p-1:0]                  data_i,
  input  logic                                     yumi_i,
  input  logic                                     data_v_i,
  input  logic [data_width_p-1:0]                  read_data_i,
  input  logic [channel_addr_width_p-1:0]          read_done_ch_addr_i,
  input  logic                                     write_done_i,
  output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
  output logic                                     mismatch_o,
  output logic [check_width_p-1:0]                 expected_o,
  output logic                                     underflow_o,
  output logic                                     overflow_o
);

  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
  localparam int depth_lp = 2 ** shadow_addr_width_p;

  logic [check_width_p-1:0]       shadow_q [depth_lp];
  logic [cnt_w_lp-1:0]            cnt_q, cnt_d;
  logic [shadow_addr_width_p-1:0] wr_col, rd_col;
  logic                           accept, wr_v;
  int                             net;

  logic unused_bits;
  assign unused_bits = ^{data_i, ch_addr_i, read_done_ch_addr_i};

  assign accept = v_i & yumi_i;
  assign wr_v   = accept & write_not_read_i;
  assign wr_col = ch_addr_i[col_lsb_p +: shadow_addr_width_p];
  assign rd_col = read_done_ch_addr_i[col_lsb_p +: shadow_addr_width_p];

  always_ff @(posedge clk_i) begin
    if (clear_v_i)
      shadow_q[clear_idx_i] <= '0;
    else if (wr_v)
      shadow_q[wr_col] <= data_i[check_width_p-1:0];
  end

  // Old shadow value is read, so a same-cycle write never masks a return.
  assign expected_o = shadow_q[rd_col];
  assign mismatch_o = data_v_i
                    & (expected_o != read_data_i[check_width_p-1:0]);

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    net = int'(cnt_q) + int'(accept)
        - int'(data_v_i) - int'(write_done_i);
    if (net < 0) begin
      cnt_d       = '0;
      underflow_o = 1'b1;
    end else if (net > max_outstanding_p) begin
      cnt_d      = cnt_w_lp'(max_outstanding_p);
      overflow_o = 1'b1;
    end else begin
      cnt_d = cnt_w_lp'(net);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign outstanding_o = cnt_q;

endmodule

// File: rtl/bsg_nonsynth_dramsim3_scoreboard.sv
// Multi-channel dramsim3 scoreboard: shadow sweep, end-of-test drain/timeout
// sequencing, sticky error/mismatch status and first-mismatch capture.
module bsg_nonsynth_dramsim3_scoreboard
  import bsg_nonsynth_dramsim3_scoreboard_pkg::*;
#(
  parameter int num_channels_p       = 8,
  parameter int channel_addr_width_p = 29,
  parameter int data_width_p         = 512,
  parameter int check_width_p        = 32,
  parameter int col_lsb_p            = 5,
  parameter int shadow_addr_width_p  = 16,
  parameter int max_outstanding_p    = 1024,
  parameter int drain_cycles_p       = 30000,
  parameter int timeout_cycles_p     = 100000,
  parameter bit report_mismatch_p    = 1'b1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_channels_p-1:0]                v_i,
  input  logic [num_channels_p-1:0]                write_not_read_i,
  input  logic [num_channels_p-1:0][channel_addr_width_p-1:0] ch_addr_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0] data_i,
  input  logic [num_channels_p-1:0]                yumi_i,
  input  logic [num_channels_p-1:0]                data_v_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0] read_data_i,
  input  logic [num_channels_p-1:0][channel_addr_width_p-1:0] read_done_ch_addr_i,
  input  logic [num_channels_p-1:0]                write_done_i,
  input  logic                                     trace_done_i,
  output logic                                     ready_o,
  output logic [num_channels_p-1:0][$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                     mismatch_o,
  output logic [31:0]                              mismatch_count_o,
  output mismatch_s                                first_mismatch_o,
  output logic                                     error_o,
  output logic                                     done_o,
  output logic                                     timeout_o
);

  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  state_e                         state_q, state_d;
  logic [shadow_addr_width_p-1:0] idx_q, idx_d;
  logic [31:0]                    timer_q, timer_d;
  logic                           mismatch_q, mismatch_d;
  logic [31:0]                    count_q, count_d;
  mismatch_s                      first_q, first_d;
  logic                           error_q, error_d;

  logic [num_channels_p-1:0]                    accept;
  logic [num_channels_p-1:0]                    mm_li, uf_li, of_li;
  logic [num_channels_p-1:0][check_width_p-1:0] exp_li;
  logic [num_channels_p-1:0][cnt_w_lp-1:0]      cnt_li;
  logic                                         clear_v;
  logic                                         activity, all_zero;
  logic                                         mm_any, err_ev, found;
  logic [31:0]                                  mm_num;

  assign accept   = v_i & yumi_i;
  assign activity = |{accept, data_v_i, write_done_i};
  assign clear_v  = (state_q == CLEAR);
  assign mm_any   = |mm_li;

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    bsg_nonsynth_dramsim3_scoreboard_channel #(
      .channel_addr_width_p(channel_addr_width_p),
      .data_width_p        (data_width_p),
      .check_width_p       (check_width_p),
      .col_lsb_p           (col_lsb_p),
      .shadow_addr_width_p (shadow_addr_width_p),
      .max_outstanding_p   (max_outstanding_p)
    ) u_ch (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .clear_v_i          (clear_v),
      .clear_idx_i        (idx_q),
      .v_i                (v_i[c]),
      .write_not_read_i   (write_not_read_i[c]),
      .ch_addr_i          (ch_addr_i[c]),
      .data_i             (data_i[c]),
      .yumi_i             (yumi_i[c]),
      .data_v_i           (data_v_i[c]),
      .read_data_i        (read_data_i[c]),
      .read_done_ch_addr_i(read_done_ch_addr_i[c]),
      .write_done_i       (write_done_i[c]),
      .outstanding_o      (cnt_li[c]),
      .mismatch_o         (mm_li[c]),
      .expected_o         (exp_li[c]),
      .underflow_o        (uf_li[c]),
      .overflow_o         (of_li[c])
    );
  end

  always_comb begin
    all_zero = 1'b1;
    for (int c = 0; c < num_channels_p; c++)
      if (cnt_li[c] != '0) all_zero = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_ev  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        idx_d  = idx_q + shadow_addr_width_p'(1);
        err_ev = |accept;
        if (&idx_q) state_d = RUN;
      end
      RUN: begin
        if (!trace_done_i) begin
          timer_d = '0;
        end else if (all_zero && !activity) begin
          state_d = DRAIN;
          timer_d = '0;
        end else if (timer_q == 32'(timeout_cycles_p - 1)) begin
          state_d = TIMEOUT;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      DRAIN: begin
        // Late traffic is an error and restarts the quiet window.
        if (activity) begin
          err_ev  = 1'b1;
          timer_d = '0;
        end else if (timer_q == 32'(drain_cycles_p - 1)) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mm_num = '0;
    for (int c = 0; c < num_channels_p; c++)
      mm_num = mm_num + 32'(mm_li[c]);
    mismatch_d = mismatch_q | mm_any;
    count_d    = sat_add32(count_q, mm_num);
    error_d    = error_q | err_ev | (|uf_li) | (|of_li);
    first_d    = first_q;
    found      = 1'b0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (!mismatch_q && mm_li[c] && !found) begin
        found            = 1'b1;
        first_d.ch       = mm_ch_width_gp'(c);
        first_d.addr     = mm_addr_width_gp'(read_done_ch_addr_i[c]);
        first_d.expected = mm_data_width_gp'(exp_li[c]);
        first_d.actual   = mm_data_width_gp'(read_data_i[c][check_width_p-1:0]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      timer_q    <= '0;
      mismatch_q <= 1'b0;
      count_q    <= '0;
      first_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      mismatch_q <= mismatch_d;
      count_q    <= count_d;
      first_q    <= first_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (report_mismatch_p && !reset_i && mm_any)
      $error("dramsim3 scoreboard: read data mismatch, channels %b", mm_li);
  end

  assign ready_o          = (state_q != CLEAR);
  assign outstanding_o    = cnt_li;
  assign mismatch_o       = mismatch_q;
  assign mismatch_count_o = count_q;
  assign first_mismatch_o = first_q;
  assign error_o          = error_q;
  assign done_o           = (state_q == DONE) & ~mismatch_q & ~error_q;
  assign timeout_o        = (state_q == TIMEOUT);

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_scoreboard.sv
// Directed bench for the dramsim3 scoreboard with a small shadow and
// short drain/timeout windows.
module tb_bsg_nonsynth_dramsim3_scoreboard;
  import bsg_nonsynth_dramsim3_scoreboard_pkg::*;

  localparam int NC   = 8;
  localparam int AW   = 29;
  localparam int DW   = 64;
  localparam int CW   = 32;
  localparam int SW   = 4;
  localparam int MAXO = 4;
  localparam int DRN  = 20;
  localparam int TO   = 40;
  localparam int CNTW = $clog2(MAXO + 1);

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [NC-1:0]          v_i, wnr_i, yumi_i, data_v_i, write_done_i;
  logic [NC-1:0][AW-1:0]  ch_addr_i, rd_addr_i;
  logic [NC-1:0][DW-1:0]  data_i, read_data_i;
  logic                   trace_done_i;
  logic                   ready_o, mismatch_o, error_o, done_o, timeout_o;
  logic [NC-1:0][CNTW-1:0] outstanding_o;
  logic [31:0]            mismatch_count_o;
  mismatch_s              first_mismatch_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bsg_nonsynth_dramsim3_scoreboard #(
    .num_channels_p(NC), .channel_addr_width_p(AW), .data_width_p(DW),
    .check_width_p(CW), .col_lsb_p(5), .shadow_addr_width_p(SW),
    .max_outstanding_p(MAXO), .drain_cycles_p(DRN),
    .timeout_cycles_p(TO), .report_mismatch_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i),
    .write_not_read_i(wnr_i), .ch_addr_i(ch_addr_i), .data_i(data_i),
    .yumi_i(yumi_i), .data_v_i(data_v_i), .read_data_i(read_data_i),
    .read_done_ch_addr_i(rd_addr_i), .write_done_i(write_done_i),
    .trace_done_i(trace_done_i), .ready_o(ready_o),
    .outstanding_o(outstanding_o), .mismatch_o(mismatch_o),
    .mismatch_count_o(mismatch_count_o),
    .first_mismatch_o(first_mismatch_o), .error_o(error_o),
    .done_o(done_o), .timeout_o(timeout_o)
  );

  task automatic idle();
    v_i = '0; wnr_i = '0; yumi_i = '0; data_v_i = '0; write_done_i = '0;
    ch_addr_i = '0; rd_addr_i = '0; data_i = '0; read_data_i = '0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic req(input int c, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    v_i[c] = 1'b1; yumi_i[c] = 1'b1; wnr_i[c] = w;
    ch_addr_i[c] = a; data_i[c] = d;
  endtask

  task automatic ret(input int c, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    data_v_i[c] = 1'b1; rd_addr_i[c] = a; read_data_i[c] = d;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; trace_done_i = 1'b0; idle();
    @(negedge clk); @(negedge clk);
    reset_i = 1'b0;
    repeat (2 ** SW + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset_i = 1'b1; trace_done_i = 1'b0; idle();
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) $display("FAIL rst_ready got %0h want 0", ready_o); else passed++;
    checks++; if (outstanding_o !== '0) $display("FAIL rst_outstanding got %0h want 0", outstanding_o); else passed++;
    checks++; if ({mismatch_o, error_o, done_o, timeout_o} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {mismatch_o, error_o, done_o, timeout_o}); else passed++;
    checks++; if (mismatch_count_o !== 32'd0 || first_mismatch_o !== '0) $display("FAIL rst_mm_info got %0h/%0h want 0/0", mismatch_count_o, first_mismatch_o); else passed++;
    reset_i = 1'b0;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != 2 ** SW) $display("FAIL clear_len got %0d want %0d", n, 2 ** SW); else passed++;
  endtask

  task automatic test_write_read();
    int n;
    do_reset();
    req(0, 1'b1, 29'h40, 64'hCAFE_0000_DEAD_BEEF); step();
    checks++; if (outstanding_o[0] !== 3'd1) $display("FAIL wr_acc_out got %0d want 1", outstanding_o[0]); else passed++;
    write_done_i[0] = 1'b1; step();
    checks++; if (outstanding_o[0] !== 3'd0) $display("FAIL wr_done_out got %0d want 0", outstanding_o[0]); else passed++;
    req(0, 1'b0, 29'h40, '0); step();
    checks++; if (outstanding_o[0] !== 3'd1) $display("FAIL rd_acc_out got %0d want 1", outstanding_o[0]); else passed++;
    ret(0, 29'h40, 64'h1234_5678_DEAD_BEEF); step();
    checks++; if (outstanding_o[0] !== 3'd0 || mismatch_o !== 1'b0) $display("FAIL rd_ret got out=%0d mm=%0d want 0/0", outstanding_o[0], mismatch_o); else passed++;
    trace_done_i = 1'b1;
    n = 0;
    while (done_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n != DRN + 1) $display("FAIL drain_done got %0d want %0d", n, DRN + 1); else passed++;
    checks++; if (error_o !== 1'b0 || mismatch_count_o !== 32'd0) $display("FAIL drain_clean got err=%0d cnt=%0d want 0/0", error_o, mismatch_count_o); else passed++;
  endtask

  task automatic test_mismatch();
    mismatch_s exp_mm;
    do_reset();
    req(3, 1'b0, 29'h80, '0); step();
    ret(3, 29'h80, 64'h1); step();
    exp_mm = '{ch: 8'd3, addr: 64'h80, expected: 64'h0, actual: 64'h1};
    checks++; if (mismatch_o !== 1'b1 || mismatch_count_o !== 32'd1) $display("FAIL mm_flag got mm=%0d cnt=%0d want 1/1", mismatch_o, mismatch_count_o); else passed++;
    checks++; if (first_mismatch_o !== exp_mm) $display("FAIL mm_first got %0h want %0h", first_mismatch_o, exp_mm); else passed++;
    trace_done_i = 1'b1;
    repeat (DRN + 4) @(negedge clk);
    checks++; if (done_o !== 1'b0 || timeout_o !== 1'b0 || error_o !== 1'b0) $display("FAIL mm_done got d=%0d t=%0d e=%0d want 0/0/0", done_o, timeout_o, error_o); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    req(2, 1'b0, 29'h20, '0); req(5, 1'b0, 29'h60, '0); step();
    ret(2, 29'h20, 64'h22); ret(5, 29'h60, 64'h55); step();
    checks++; if (mismatch_count_o !== 32'd2) $display("FAIL tie_count got %0d want 2", mismatch_count_o); else passed++;
    checks++; if (first_mismatch_o.ch !== 8'd2 || first_mismatch_o.actual !== 64'h22) $display("FAIL tie_first got ch=%0d act=%0h want 2/22", first_mismatch_o.ch, first_mismatch_o.actual); else passed++;
    req(1, 1'b0, 29'h20, '0); step();
    ret(1, 29'h20, 64'h7); step();
    checks++; if (mismatch_count_o !== 32'd3 || first_mismatch_o.ch !== 8'd2) $display("FAIL tie_sticky got cnt=%0d ch=%0d want 3/2", mismatch_count_o, first_mismatch_o.ch); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req(7, 1'b1, 29'h00, 64'h1111); step();
    req(7, 1'b1, 29'h20, 64'h2222); write_done_i[7] = 1'b1; step();
    checks++; if (outstanding_o[7] !== 3'd1) $display("FAIL b2b_net0 got %0d want 1", outstanding_o[7]); else passed++;
    req(7, 1'b0, 29'h00, '0); write_done_i[7] = 1'b1; step();
    ret(7, 29'h00, 64'h1111); req(7, 1'b1, 29'h00, 64'h3333); step();
    checks++; if (outstanding_o[7] !== 3'd1 || mismatch_o !== 1'b0) $display("FAIL b2b_rw got out=%0d mm=%0d want 1/0", outstanding_o[7], mismatch_o); else passed++;
    write_done_i[7] = 1'b1; step();
    req(7, 1'b0, 29'h00, '0); step();
    ret(7, 29'h00, 64'h3333); step();
    req(7, 1'b0, 29'h20, '0); step();
    ret(7, 29'h20, 64'h2222); step();
    checks++; if (outstanding_o[7] !== 3'd0 || mismatch_count_o !== 32'd0 || error_o !== 1'b0) $display("FAIL b2b_end got out=%0d cnt=%0d err=%0d want 0/0/0", outstanding_o[7], mismatch_count_o, error_o); else passed++;
  endtask

  task automatic test_errors();
    do_reset();
    write_done_i[1] = 1'b1; step();
    checks++; if (error_o !== 1'b1 || outstanding_o[1] !== 3'd0) $display("FAIL underflow got err=%0d out=%0d want 1/0", error_o, outstanding_o[1]); else passed++;
    do_reset();
    repeat (MAXO) begin req(0, 1'b0, 29'h0, '0); step(); end
    checks++; if (outstanding_o[0] !== 3'(MAXO) || error_o !== 1'b0) $display("FAIL ovf_fill got out=%0d err=%0d want %0d/0", outstanding_o[0], error_o, MAXO); else passed++;
    req(0, 1'b0, 29'h0, '0); step();
    checks++; if (outstanding_o[0] !== 3'(MAXO) || error_o !== 1'b1) $display("FAIL overflow got out=%0d err=%0d want %0d/1", outstanding_o[0], error_o, MAXO); else passed++;
    do_reset();
    trace_done_i = 1'b1; step();
    repeat (5) step();
    ret(4, 29'h0, 64'h0); step();
    checks++; if (error_o !== 1'b1 || mismatch_o !== 1'b0) $display("FAIL drain_late got err=%0d mm=%0d want 1/0", error_o, mismatch_o); else passed++;
    repeat (DRN + 4) @(negedge clk);
    checks++; if (done_o !== 1'b0) $display("FAIL drain_err_done got %0d want 0", done_o); else passed++;
    reset_i = 1'b1; trace_done_i = 1'b0; idle();
    @(negedge clk); reset_i = 1'b0;
    @(negedge clk);
    req(0, 1'b0, 29'h0, '0); step();
    checks++; if (error_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL clear_req got err=%0d rdy=%0d want 1/0", error_o, ready_o); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req(6, 1'b0, 29'h40, '0); step();
    trace_done_i = 1'b1;
    n = 0;
    while (timeout_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n != TO) $display("FAIL timeout_len got %0d want %0d", n, TO); else passed++;
    checks++; if (done_o !== 1'b0) $display("FAIL timeout_done got %0d want 0", done_o); else passed++;
    do_reset();
    req(6, 1'b0, 29'h40, '0); step();
    checks++; if (outstanding_o[6] !== 3'd1 || ready_o !== 1'b1) $display("FAIL midrun_pre got out=%0d rdy=%0d want 1/1", outstanding_o[6], ready_o); else passed++;
    #2 reset_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b0 || outstanding_o[6] !== 3'd0) $display("FAIL midrun_rst got rdy=%0d out=%0d want 0/0", ready_o, outstanding_o[6]); else passed++;
    @(negedge clk); reset_i = 1'b0;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != 2 ** SW) $display("FAIL midrun_clear got %0d want %0d", n, 2 ** SW); else passed++;
  endtask

  initial begin
    reset_i = 1'b1; trace_done_i = 1'b0; idle();
    test_reset();
    test_write_read();
    test_mismatch();
    test_same_cycle();
    test_back_to_back();
    test_errors();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
